// File: rtl/jk_latch_driver.sv
// jk_latch_driver: sequences hold/set/reset/toggle commands into timed J/K/enable pulses for a JK latch
// Ports: clk, rst_n (async active-low); cmd_valid/cmd/cmd_ready command handshake;
//        J, K, enable drive the latch; q_model is the expected latch Q; busy, done and
//        cmd_count report sequencing progress. All outputs are registered.
module jk_latch_driver #(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    output logic             J,
    output logic             K,
    output logic             enable,
    output logic             q_model,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cmd_count
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;
    // The timer counts down to zero, so each state loads its length minus one.
    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYCLES - 1);
    logic [1:0]       state_q, state_d;
    logic [3:0]       timer_q, timer_d;
    logic             j_q, j_d, k_q, k_d, en_q, en_d, qm_q, qm_d;
    logic             done_q, done_d, busy_q, busy_d, ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q != 4'd0) ? timer_q - 4'd1 : timer_q;
        j_d     = j_q;
        k_d     = k_q;
        en_d    = en_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_valid && ready_q) begin
                state_d = S_SETUP;
                timer_d = SETUP_LD;
                j_d     = cmd[1];
                k_d     = cmd[0];
            end
            S_SETUP: if (timer_q == 4'd0) begin
                state_d = S_PULSE;
                timer_d = PULSE_LD;
                en_d    = 1'b1;
            end
            S_PULSE: if (timer_q == 4'd0) begin
                state_d = S_HOLD;
                timer_d = HOLD_LD;
                en_d    = 1'b0;
                // Single update per command: toggle inverts once however long the pulse is.
                qm_d    = j_q ? (k_q ? ~qm_q : 1'b1) : (k_q ? 1'b0 : qm_q);
            end
            default: if (timer_q == 4'd0) begin
                state_d = S_IDLE;
                j_d     = 1'b0;
                k_d     = 1'b0;
                done_d  = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= 4'd0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            en_q    <= 1'b0;
            qm_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            j_q     <= j_d;
            k_q     <= k_d;
            en_q    <= en_d;
            qm_q    <= qm_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end
    assign cmd_ready = ready_q;
    assign J         = j_q;
    assign K         = k_q;
    assign enable    = en_q;
    assign q_model   = qm_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_count = cnt_q;
endmodule

// File: tb/tb_jk_latch_driver.sv
// tb_jk_latch_driver: directed checks of the JK latch command sequencer (default and 2-bit counter builds)
module tb_jk_latch_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_ready, J, K, enable, q_model, busy, done;
    logic [7:0] cmd_count;
    logic       w_ready, w_j, w_k, w_en, w_q, w_busy, w_done;
    logic [1:0] w_count;
    int         errors = 0;
    int         checks = 0;
    int         exp_cnt = 0;
    logic       q_exp = 1'b0;
    jk_latch_driver dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .J(J), .K(K), .enable(enable), .q_model(q_model),
        .busy(busy), .done(done), .cmd_count(cmd_count)
    );
    jk_latch_driver #(.CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(w_ready), .J(w_j), .K(w_k), .enable(w_en), .q_model(w_q),
        .busy(w_busy), .done(w_done), .cmd_count(w_count)
    );
    always #5 clk = ~clk;
    function automatic logic [6:0] obs();
        return {cmd_ready, busy, J, K, enable, q_model, done};
    endfunction
    // Expected {ready,busy,J,K,enable,q,done} in cycle n (1..5) after accepting command c.
    function automatic logic [6:0] exp_vec(int n, logic [1:0] c, logic qo);
        logic act = (n >= 1 && n <= 4);
        logic qn  = c[1] ? (c[0] ? ~qo : 1'b1) : (c[0] ? 1'b0 : qo);
        return {n == 5, act, act & c[1], act & c[0], n == 2 || n == 3, n >= 4 ? qn : qo, n == 5};
    endfunction
    // Called at a negedge while idle; returns at the negedge of cycle 5.
    task automatic test_command(input logic [1:0] c, input logic keep);
        logic [6:0] e;
        cmd_valid = 1'b1;
        cmd = c;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1 && !keep) cmd_valid = 1'b0;
            if (n == 2) cmd = ~c;
            if (n == 3) cmd = c;
            if (n == 5) exp_cnt++;
            e = exp_vec(n, c, q_exp);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL cmd%b cycle%0d rdy/busy/J/K/en/q/done got=%b exp=%b", c, n, obs(), e);
            end
            if (n == 1 || n == 5) begin
                checks++;
                if (cmd_count !== 8'(exp_cnt) || w_count !== 2'(exp_cnt)) begin
                    errors++;
                    $display("FAIL count cmd%b cycle%0d got=%0d/%0d exp=%0d/%0d", c, n,
                             cmd_count, w_count, 8'(exp_cnt), 2'(exp_cnt));
                end
            end
        end
        q_exp = e[1];
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        q_exp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 7'b1000000 || cmd_count !== 8'd0 || w_count !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle cycle%0d got=%b cnt=%0d exp=1000000 cnt=0", i, obs(), cmd_count);
            end
        end
    endtask
    task automatic test_set_reset();
        test_command(2'b10, 1'b0);
        test_command(2'b01, 1'b0);
        checks++;
        if (q_model !== 1'b0 || cmd_count !== 8'd2) begin
            errors++;
            $display("FAIL set_reset got q=%b cnt=%0d exp q=0 cnt=2", q_model, cmd_count);
        end
    endtask
    task automatic test_back_to_back();
        test_command(2'b11, 1'b1);
        test_command(2'b11, 1'b1);
        cmd_valid = 1'b0;
        checks++;
        if (q_model !== 1'b0 || cmd_count !== 8'd4) begin
            errors++;
            $display("FAIL back_to_back got q=%b cnt=%0d exp q=0 cnt=4", q_model, cmd_count);
        end
    endtask
    task automatic test_hold();
        test_command(2'b10, 1'b0);
        test_command(2'b00, 1'b0);
        checks++;
        if (q_model !== 1'b1 || cmd_count !== 8'd6) begin
            errors++;
            $display("FAIL hold got q=%b cnt=%0d exp q=1 cnt=6", q_model, cmd_count);
        end
    endtask
    task automatic test_reset_mid_pulse();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        q_exp = 1'b0;
        test_command(2'b10, 1'b0);
        cmd_valid = 1'b1;
        cmd = 2'b10;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (enable !== 1'b1 || q_model !== 1'b1) begin
            errors++;
            $display("FAIL mid_pulse_pre got en=%b q=%b exp en=1 q=1", enable, q_model);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (enable !== 1'b0 || q_model !== 1'b0 || cmd_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_pulse_rst got en=%b q=%b cnt=%0d busy=%b exp 0 0 0 0", enable, q_model, cmd_count, busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            checks++;
            if (done !== 1'b0 || cmd_count !== 8'd0 || enable !== 1'b0) begin
                errors++;
                $display("FAIL mid_pulse_after%0d got done=%b cnt=%0d en=%b exp 0 0 0", i, done, cmd_count, enable);
            end
        end
        exp_cnt = 0;
        q_exp = 1'b0;
        test_command(2'b10, 1'b0);
    endtask
    task automatic test_wrap();
        logic [1:0] cmds [5] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        q_exp = 1'b0;
        for (int i = 0; i < 5; i++) test_command(cmds[i], 1'b0);
        checks++;
        if (w_count !== 2'd1 || cmd_count !== 8'd5 || w_q !== 1'b0) begin
            errors++;
            $display("FAIL wrap got w=%0d cnt=%0d q=%b exp w=1 cnt=5 q=0", w_count, cmd_count, w_q);
        end
    endtask
    initial begin
        test_reset();
        test_set_reset();
        test_back_to_back();
        test_hold();
        test_reset_mid_pulse();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
